data_ram_256x16: RTL and testbench
==================================

Name: data_ram_256x16

Overview:
- 256-word × 16-bit single-port data memory for the single-cycle RISC datapath.
- Writes are synchronous on the rising clock edge when Write_En is high.
- Reads are combinational, so a load completes within the same cycle.
- Synchronous active-high reset clears the whole array to zero.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 16, word width in bits.
- DEPTH, 256, number of words; always equal to 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  8  word address for both read and write.
- Write_En  input  1  write enable, sampled on the rising edge of clk.
- D  input  16  write data.
- O  output  16  read data, always equal to mem[Addr].

Behaviour:
- Storage: DEPTH words of DATA_W bits, held in flip-flops/distributed RAM. No block-RAM output register.
- Reset:
  - On a rising edge with reset=1, all 256 words become 16'h0000.
  - Reset has priority over Write_En; a write in the reset cycle is discarded.
  - After the reset edge, O reads 16'h0000 for every address.
  - Reset asserted mid-sequence clears previously written data at that edge.
- Write:
  - On a rising edge with reset=0 and Write_En=1: mem[Addr] <= D.
  - Exactly one word changes; all other words hold.
- Hold: with Write_En=0 (or X-free low), memory is unchanged.
- Read:
  - O = mem[Addr], purely combinational with zero-cycle latency.
  - O follows Addr changes within the same cycle.
- Read-during-write to the same address:
  - Before the edge, O shows the old contents.
  - After the edge, O shows D (no write-first bypass before the edge).
- Address range: all 8-bit values valid (0x00..0xFF). No wrap or out-of-range case exists.
- Power-up before the first reset: contents undefined (X in simulation). Initialise with reset before use.
- No handshake, no ready/valid. A write is one cycle; back-to-back writes to any addresses are allowed every cycle.
- Writing the same address on consecutive cycles: the last write wins.

Decomposition:
- Shared package (e.g. riscv_mem_pkg): constants RAM_ADDR_W=8, RAM_DATA_W=16, RAM_DEPTH=256, and typedef ram_word_t (logic [15:0]).
- One sub-module is natural: ram_word_reg, a 16-bit register with sync reset and enable.
  - Instantiate 256 times, with a one-hot enable from an 8-to-256 write decoder.
  - Output through a 256:1 × 16 read mux on Addr.
- A single behavioural array is an acceptable alternative, provided the reset-clear behaviour is kept.

Test Plan:
- Reset clear: assert reset for one edge, then sweep Addr 0x00..0xFF with Write_En=0 -> O=16'h0000 at every address.
- Write/read-back pattern:
  - With Write_En=1, write 0x12←1234, 0x34←3456, 0x56←5678, 0x78←789A, 0x9A←9ABC, 0xBC←BCDE, 0xDE←DEF0, 0xF0←F012.
  - Change inputs mid-cycle, one write per edge.
  - Then with Write_En=0 re-read each address -> O equals the written value.
  - Unwritten addresses (e.g. 0x00, 0xFF) read 0000.
- Write-enable gating: Write_En=0 with Addr=0x12, D=16'hFFFF across an edge -> mem[0x12] still 16'h1234.
- Read-during-write: Addr=0x34, D=16'hAAAA, Write_En=1.
  - Before the edge, O=16'h3456.
  - Immediately after the edge, O=16'hAAAA with no extra cycle.
- Reset priority: reset=1 and Write_En=1 with Addr=0x56, D=16'h1111 on the same edge -> afterwards mem[0x56]=0000, mem[0xF0]=0000.
- Boundary addresses: write 0x00←0001 and 0xFF←FFFE on consecutive edges -> both read back correctly, and 0x01 and 0xFE remain 0000.

Source files
------------

// File: rtl/data_ram_256x16_pkg.sv
// ---------------------------------------------------------------------------
// data_ram_256x16_pkg
//   Shared constants and types for the single-cycle RISC data memory.
//   RAM_ADDR_W : word address width
//   RAM_DATA_W : word width
//   RAM_DEPTH  : number of words (2**RAM_ADDR_W)
//   ram_word_t : one memory word
// ---------------------------------------------------------------------------
package data_ram_256x16_pkg;

    localparam int unsigned RAM_ADDR_W = 8;
    localparam int unsigned RAM_DATA_W = 16;
    localparam int unsigned RAM_DEPTH  = 256;

    typedef logic [RAM_DATA_W-1:0] ram_word_t;

endpackage : data_ram_256x16_pkg

// File: rtl/data_ram_256x16_word_reg.sv
// ---------------------------------------------------------------------------
// ram_word_reg
//   One storage word of the data memory: a register with synchronous
//   active-high clear and load enable. Clear wins over load.
//   clk   : clock, state changes on rising edge
//   reset : synchronous clear to zero
//   en    : load d on the rising edge
//   d     : load data
//   q     : stored word
// ---------------------------------------------------------------------------
module ram_word_reg #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] word_d;
    logic [DATA_W-1:0] word_q;

    always_comb begin
        word_d = word_q;
        if (en) begin
            word_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q = word_q;

endmodule : ram_word_reg

// File: rtl/data_ram_256x16.sv
// ---------------------------------------------------------------------------
// data_ram_256x16
//   Single-port data memory with synchronous write and combinational read.
//   Built from DEPTH word registers, a one-hot write decoder and a read mux.
//   clk      : clock, writes and reset act on the rising edge
//   reset    : synchronous active-high clear of every word
//   Addr     : word address shared by read and write
//   Write_En : write enable sampled on the rising edge
//   D        : write data
//   O        : read data, always mem[Addr] (old contents until the edge)
// ---------------------------------------------------------------------------
module data_ram_256x16
    import data_ram_256x16_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned DEPTH  = RAM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              Write_En,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] O
);

    logic [DEPTH-1:0]  word_sel;
    logic [DATA_W-1:0] word_rd [DEPTH];

    // One-hot write select; all zero when no write is requested.
    always_comb begin
        word_sel = '0;
        if (Write_En) begin
            word_sel[Addr] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        ram_word_reg #(
            .DATA_W (DATA_W)
        ) u_word (
            .clk   (clk),
            .reset (reset),
            .en    (word_sel[i]),
            .d     (D),
            .q     (word_rd[i])
        );
    end

    // Read straight from the registers: no bypass, so a write becomes
    // visible only after the edge that stores it.
    always_comb begin
        O = word_rd[Addr];
    end

endmodule : data_ram_256x16

// File: tb/tb_data_ram_256x16.sv
module tb_data_ram_256x16;
    import data_ram_256x16_pkg::*;

    logic            clk;
    logic            reset;
    logic [7:0]      Addr;
    logic            Write_En;
    ram_word_t       D;
    ram_word_t       O;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] addr;
        logic [15:0] d;
        logic [15:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    data_ram_256x16 #(
        .ADDR_W (8),
        .DATA_W (16),
        .DEPTH  (256)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Addr     (Addr),
        .Write_En (Write_En),
        .D        (D),
        .O        (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: O=%h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive inputs, pass one rising edge, return at
    // the next falling edge with the inputs still applied.
    task automatic step(input logic rst, input logic we, input logic [7:0] a, input logic [15:0] d);
        reset    = rst;
        Write_En = we;
        Addr     = a;
        D        = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic rst, input logic we, input logic [7:0] a,
                                input logic [15:0] d, input logic [15:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = a; v.d = d; v.exp = exp; v.name = name;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        Write_En = 1'b0;
        Addr     = 8'h00;
        D        = 16'h0000;

        // Directed table: O is checked after the edge with the same Addr.
        vecs.push_back(mk(0, 1, 8'h12, 16'h1234, 16'h1234, "wr_12"));
        vecs.push_back(mk(0, 1, 8'h34, 16'h3456, 16'h3456, "wr_34"));
        vecs.push_back(mk(0, 1, 8'h56, 16'h5678, 16'h5678, "wr_56"));
        vecs.push_back(mk(0, 1, 8'h78, 16'h789A, 16'h789A, "wr_78"));
        vecs.push_back(mk(0, 1, 8'h9A, 16'h9ABC, 16'h9ABC, "wr_9a"));
        vecs.push_back(mk(0, 1, 8'hBC, 16'hBCDE, 16'hBCDE, "wr_bc"));
        vecs.push_back(mk(0, 1, 8'hDE, 16'hDEF0, 16'hDEF0, "wr_de"));
        vecs.push_back(mk(0, 1, 8'hF0, 16'hF012, 16'hF012, "wr_f0"));
        vecs.push_back(mk(0, 0, 8'h12, 16'h0000, 16'h1234, "rd_12"));
        vecs.push_back(mk(0, 0, 8'h34, 16'h0000, 16'h3456, "rd_34"));
        vecs.push_back(mk(0, 0, 8'h56, 16'h0000, 16'h5678, "rd_56"));
        vecs.push_back(mk(0, 0, 8'h78, 16'h0000, 16'h789A, "rd_78"));
        vecs.push_back(mk(0, 0, 8'h9A, 16'h0000, 16'h9ABC, "rd_9a"));
        vecs.push_back(mk(0, 0, 8'hBC, 16'h0000, 16'hBCDE, "rd_bc"));
        vecs.push_back(mk(0, 0, 8'hDE, 16'h0000, 16'hDEF0, "rd_de"));
        vecs.push_back(mk(0, 0, 8'hF0, 16'h0000, 16'hF012, "rd_f0"));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0000, "rd_unwr_00"));
        vecs.push_back(mk(0, 0, 8'hFF, 16'h0000, 16'h0000, "rd_unwr_ff"));
        vecs.push_back(mk(0, 0, 8'h12, 16'hFFFF, 16'h1234, "we_gate_12"));
        vecs.push_back(mk(0, 1, 8'h78, 16'h1111, 16'h1111, "wr2_78_a"));
        vecs.push_back(mk(0, 1, 8'h78, 16'h2222, 16'h2222, "wr2_78_b"));
        vecs.push_back(mk(0, 0, 8'h78, 16'h0000, 16'h2222, "last_wins_78"));
        vecs.push_back(mk(0, 0, 8'h9A, 16'h0000, 16'h9ABC, "neighbor_9a"));

        // Reset for one edge, then sweep every address.
        @(negedge clk);
        step(1'b1, 1'b0, 8'h00, 16'h0000);
        reset = 1'b0;
        for (int a = 0; a < 256; a++) begin
            Addr = 8'(a);
            #2;
            check($sformatf("reset_clear_%02h", a), O, 16'h0000);
            @(negedge clk);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].d);
            check(vecs[i].name, O, vecs[i].exp);
        end

        // Read-during-write: old contents before the edge, new right after.
        reset    = 1'b0;
        Addr     = 8'h34;
        D        = 16'hAAAA;
        Write_En = 1'b1;
        #1;
        check("rdw_before_edge", O, 16'h3456);
        @(posedge clk);
        #1;
        check("rdw_after_edge", O, 16'hAAAA);
        @(negedge clk);

        // Reset beats a simultaneous write and clears earlier data.
        step(1'b1, 1'b1, 8'h56, 16'h1111);
        check("rst_prio_56", O, 16'h0000);
        step(1'b0, 1'b0, 8'hF0, 16'h0000);
        check("rst_clear_f0", O, 16'h0000);
        step(1'b0, 1'b0, 8'h34, 16'h0000);
        check("rst_clear_34", O, 16'h0000);

        // Boundary addresses on consecutive edges.
        step(1'b0, 1'b1, 8'h00, 16'h0001);
        check("wr_00", O, 16'h0001);
        step(1'b0, 1'b1, 8'hFF, 16'hFFFE);
        check("wr_ff", O, 16'hFFFE);
        step(1'b0, 1'b0, 8'h00, 16'h0000);
        check("rd_00", O, 16'h0001);
        step(1'b0, 1'b0, 8'hFF, 16'h0000);
        check("rd_ff", O, 16'hFFFE);
        step(1'b0, 1'b0, 8'h01, 16'h0000);
        check("rd_01", O, 16'h0000);
        step(1'b0, 1'b0, 8'hFE, 16'h0000);
        check("rd_fe", O, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_data_ram_256x16
